alu: RTL and testbench



---
 rtl/alu_if.sv | 26 ++
 rtl/alu.sv | 175 +++++++++++++++++
 tb/tb_alu.sv | 129 ++++++++++++
 3 files changed

// File: rtl/alu_if.sv
// Operand/result bundle for the registered ALU: the master drives operands and
// opcode, the slave (the ALU) returns the registered result and status flags.
interface alu_if #(
   parameter int WIDTH = 4
);
   logic [WIDTH-1:0] A;
   logic [WIDTH-1:0] B;
   logic             Cin;
   logic [3:0]       OPCODE;
   logic [WIDTH-1:0] Y;
   logic             N;
   logic             Z;
   logic             C;
   logic             V;
   logic             Cout;

   modport master (
      output A, B, Cin, OPCODE,
      input  Y, N, Z, C, V, Cout
   );

   modport slave (
      input  A, B, Cin, OPCODE,
      output Y, N, Z, C, V, Cout
   );
endinterface

// File: rtl/alu.sv
// 4-bit registered ALU: result and N/Z/C/V/Cout appear one clock after operands.
// Define ALU_EXT_OPS_EN to enable SBC/ASR/ROL/ROR/INC/DEC on opcodes 1010-1111.
module alu #(
   parameter int WIDTH = 4
) (
   input  logic  clk,
   input  logic  rst,
   alu_if.slave  bus
);

   typedef enum logic [3:0] {
      OP_PASS = 4'b0000,
      OP_AND  = 4'b0001,
      OP_OR   = 4'b0010,
      OP_NOT  = 4'b0011,
      OP_XOR  = 4'b0100,
      OP_ADD  = 4'b0101,
      OP_SHL  = 4'b0110,
      OP_SHR  = 4'b0111,
      OP_ADC  = 4'b1000,
      OP_SUB  = 4'b1001,
      OP_SBC  = 4'b1010,
      OP_ASR  = 4'b1011,
      OP_ROL  = 4'b1100,
      OP_ROR  = 4'b1101,
      OP_INC  = 4'b1110,
      OP_DEC  = 4'b1111
   } opcode_t;

   localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

   opcode_t          w_op;
   logic [1:0]       w_shamt;

   logic [WIDTH-1:0] w_add_b;
   logic             w_add_cin;
   logic [WIDTH:0]   w_sum;
   logic             w_ovf;

   logic [WIDTH:0]   w_shl_ext;
   logic [WIDTH:0]   w_shr_ext;
`ifdef ALU_EXT_OPS_EN
   logic [WIDTH:0]   w_asr_ext;
   logic [WIDTH-1:0] w_rol;
   logic [WIDTH-1:0] w_ror;
`endif

   logic [WIDTH-1:0] w_y;
   logic             w_c;
   logic             w_v;
   logic             w_cout;

   logic [WIDTH-1:0] r_y;
   logic             r_n;
   logic             r_z;
   logic             r_c;
   logic             r_v;
   logic             r_cout;

   assign w_op    = opcode_t'(bus.OPCODE);
   assign w_shamt = bus.B[1:0];

   // One shared adder; A is always the first input, only B and carry-in vary.
   // NOTE: every variable gets a default before the case so no opcode path
   // can leave one unassigned and infer a latch.
   always_comb begin
      w_add_b   = bus.B;
      w_add_cin = 1'b0;
      case (w_op)
         OP_ADC: w_add_cin = bus.Cin;
         OP_SUB: begin
            w_add_b   = ~bus.B;
            w_add_cin = 1'b1;
         end
`ifdef ALU_EXT_OPS_EN
         OP_SBC: begin
            w_add_b   = ~bus.B;
            w_add_cin = bus.Cin;
         end
         OP_INC: w_add_b = ONE;
         OP_DEC: w_add_b = '1;
`endif
         default: ;
      endcase
   end

   assign w_sum = {1'b0, bus.A} + {1'b0, w_add_b} + {{WIDTH{1'b0}}, w_add_cin};
   assign w_ovf = (bus.A[WIDTH-1] == w_add_b[WIDTH-1]) &&
                  (w_sum[WIDTH-1] != bus.A[WIDTH-1]);

   // The extra bit on each shifter catches the last bit shifted out, and is
   // naturally 0 when the amount is 0.
   assign w_shl_ext = {1'b0, bus.A} << w_shamt;
   assign w_shr_ext = {bus.A, 1'b0} >> w_shamt;
`ifdef ALU_EXT_OPS_EN
   assign w_asr_ext = $signed({bus.A, 1'b0}) >>> w_shamt;
   assign w_rol     = (bus.A << w_shamt) | (bus.A >> (WIDTH - int'(w_shamt)));
   assign w_ror     = (bus.A >> w_shamt) | (bus.A << (WIDTH - int'(w_shamt)));
`endif

   always_comb begin
      w_y    = '0;
      w_c    = 1'b0;
      w_v    = 1'b0;
      w_cout = 1'b0;
      case (w_op)
         OP_PASS: w_y = bus.A;
         OP_AND:  w_y = bus.A & bus.B;
         OP_OR:   w_y = bus.A | bus.B;
         OP_NOT:  w_y = ~bus.A;
         OP_XOR:  w_y = bus.A ^ bus.B;
`ifdef ALU_EXT_OPS_EN
         OP_ADD, OP_ADC, OP_SUB, OP_SBC, OP_INC, OP_DEC: begin
`else
         OP_ADD, OP_ADC, OP_SUB: begin
`endif
            w_y    = w_sum[WIDTH-1:0];
            w_c    = w_sum[WIDTH];
            w_cout = w_sum[WIDTH];
            w_v    = w_ovf;
         end
         OP_SHL: begin
            w_y = w_shl_ext[WIDTH-1:0];
            w_c = w_shl_ext[WIDTH];
         end
         OP_SHR: begin
            w_y = w_shr_ext[WIDTH:1];
            w_c = w_shr_ext[0];
         end
`ifdef ALU_EXT_OPS_EN
         OP_ASR: begin
            w_y = w_asr_ext[WIDTH:1];
            w_c = w_asr_ext[0];
         end
         OP_ROL: begin
            w_y = w_rol;
            w_c = (w_shamt != 2'd0) && w_rol[0];
         end
         OP_ROR: begin
            w_y = w_ror;
            w_c = (w_shamt != 2'd0) && w_ror[WIDTH-1];
         end
`endif
         default: ;
      endcase
   end

   // NOTE: state registers use non-blocking assignments so every flop samples
   // the pre-edge values, independent of statement order.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_y    <= '0;
         r_n    <= 1'b0;
         r_z    <= 1'b0;
         r_c    <= 1'b0;
         r_v    <= 1'b0;
         r_cout <= 1'b0;
      end else begin
         r_y    <= w_y;
         r_n    <= w_y[WIDTH-1];
         r_z    <= (w_y == '0);
         r_c    <= w_c;
         r_v    <= w_v;
         r_cout <= w_cout;
      end
   end

   assign bus.Y    = r_y;
   assign bus.N    = r_n;
   assign bus.Z    = r_z;
   assign bus.C    = r_c;
   assign bus.V    = r_v;
   assign bus.Cout = r_cout;

endmodule

// File: tb/tb_alu.sv
// Directed-vector bench for the registered ALU; expected values are packed as
// {Y, N, Z, C, V, Cout} and were worked out by hand.
module tb_alu;

   localparam logic [3:0] OP_PASS = 4'b0000;
   localparam logic [3:0] OP_AND  = 4'b0001;
   localparam logic [3:0] OP_OR   = 4'b0010;
   localparam logic [3:0] OP_NOT  = 4'b0011;
   localparam logic [3:0] OP_XOR  = 4'b0100;
   localparam logic [3:0] OP_ADD  = 4'b0101;
   localparam logic [3:0] OP_SHL  = 4'b0110;
   localparam logic [3:0] OP_SHR  = 4'b0111;
   localparam logic [3:0] OP_ADC  = 4'b1000;
   localparam logic [3:0] OP_SUB  = 4'b1001;

   logic clk;
   logic rst;
   int   n_checks;
   int   n_errors;
   logic have_prev;
   logic [8:0] prev_exp;

   alu_if #(.WIDTH(4)) bus ();

   alu #(.WIDTH(4)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [8:0] observed();
      return {bus.Y, bus.N, bus.Z, bus.C, bus.V, bus.Cout};
   endfunction

   task automatic check(input string tag, input logic [8:0] obs, input logic [8:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got Y=%b NZCV=%b Cout=%b, expected Y=%b NZCV=%b Cout=%b",
                  tag, obs[8:5], obs[4:1], obs[0], exp[8:5], exp[4:1], exp[0]);
      end
   endtask

   // Drive one op mid-cycle, confirm outputs have not moved yet, then check the
   // result just after the next rising edge.
   task automatic apply(input string tag, input logic rst_v, input logic [3:0] op,
                        input logic [3:0] a, input logic [3:0] b, input logic cin,
                        input logic [8:0] exp);
      @(negedge clk);
      rst        = rst_v;
      bus.OPCODE = op;
      bus.A      = a;
      bus.B      = b;
      bus.Cin    = cin;
      #1;
      if (have_prev) check({tag, "_hold"}, observed(), prev_exp);
      @(posedge clk);
      #1;
      check(tag, observed(), exp);
      prev_exp  = exp;
      have_prev = 1'b1;
   endtask

   initial begin
      n_checks   = 0;
      n_errors   = 0;
      have_prev  = 1'b0;
      prev_exp   = '0;
      rst        = 1'b1;
      bus.OPCODE = OP_ADD;
      bus.A      = 4'hF;
      bus.B      = 4'hF;
      bus.Cin    = 1'b1;

      //      tag          rst   op       A        B        Cin   {Y, N Z C V Cout}
      apply("reset",       1'b1, OP_ADD,  4'b1111, 4'b1111, 1'b1, 9'b0000_00000);
      apply("pass_zero",   1'b0, OP_PASS, 4'b0000, 4'b0000, 1'b0, 9'b0000_01000);
      apply("pass",        1'b0, OP_PASS, 4'b1010, 4'b0101, 1'b1, 9'b1010_10000);
      apply("and",         1'b0, OP_AND,  4'b1001, 4'b0101, 1'b0, 9'b0001_00000);
      apply("or",          1'b0, OP_OR,   4'b0101, 4'b0011, 1'b0, 9'b0111_00000);
      apply("not",         1'b0, OP_NOT,  4'b1111, 4'b0110, 1'b0, 9'b0000_01000);
      apply("xor",         1'b0, OP_XOR,  4'b1001, 4'b1010, 1'b0, 9'b0011_00000);
      apply("add",         1'b0, OP_ADD,  4'b0001, 4'b0011, 1'b1, 9'b0100_00000);
      apply("adc_wrap",    1'b0, OP_ADC,  4'b0001, 4'b1111, 1'b0, 9'b0000_01101);
      apply("adc_cin",     1'b0, OP_ADC,  4'b0111, 4'b0000, 1'b1, 9'b1000_10010);
      apply("add_ovf",     1'b0, OP_ADD,  4'b0111, 4'b0001, 1'b0, 9'b1000_10010);
      apply("add_carry",   1'b0, OP_ADD,  4'b1111, 4'b0001, 1'b0, 9'b0000_01101);
      apply("sub_ovf",     1'b0, OP_SUB,  4'b1000, 4'b0010, 1'b0, 9'b0110_00111);
      apply("sub_borrow",  1'b0, OP_SUB,  4'b0001, 4'b0011, 1'b1, 9'b1110_10000);
      apply("shl2",        1'b0, OP_SHL,  4'b1000, 4'b0010, 1'b0, 9'b0000_01000);
      apply("shl1",        1'b0, OP_SHL,  4'b1000, 4'b0001, 1'b0, 9'b0000_01100);
      apply("shl3",        1'b0, OP_SHL,  4'b0111, 4'b1111, 1'b0, 9'b1000_10100);
      apply("shl0",        1'b0, OP_SHL,  4'b0110, 4'b1100, 1'b0, 9'b0110_00000);
      apply("shr2",        1'b0, OP_SHR,  4'b0100, 4'b0010, 1'b0, 9'b0001_00000);
      apply("shr1",        1'b0, OP_SHR,  4'b0101, 4'b0001, 1'b0, 9'b0010_00100);
      apply("shr3",        1'b0, OP_SHR,  4'b0110, 4'b0011, 1'b0, 9'b0000_01100);
      apply("shr0",        1'b0, OP_SHR,  4'b1011, 4'b0100, 1'b0, 9'b1011_10000);
      apply("mid_reset",   1'b1, OP_ADD,  4'b1111, 4'b0001, 1'b0, 9'b0000_00000);
      apply("post_reset",  1'b0, OP_XOR,  4'b1100, 4'b0101, 1'b0, 9'b1001_10000);

`ifdef ALU_EXT_OPS_EN
      apply("sbc_cin1",    1'b0, 4'b1010, 4'b0101, 4'b0011, 1'b1, 9'b0010_00101);
      apply("sbc_cin0",    1'b0, 4'b1010, 4'b0101, 4'b0011, 1'b0, 9'b0001_00101);
      apply("asr1",        1'b0, 4'b1011, 4'b1000, 4'b0001, 1'b0, 9'b1100_10000);
      apply("asr2",        1'b0, 4'b1011, 4'b1011, 4'b0010, 1'b0, 9'b1110_10100);
      apply("rol1",        1'b0, 4'b1100, 4'b1001, 4'b0001, 1'b0, 9'b0011_00100);
      apply("rol0",        1'b0, 4'b1100, 4'b1001, 4'b0000, 1'b0, 9'b1001_10000);
      apply("ror1",        1'b0, 4'b1101, 4'b1001, 4'b0001, 1'b0, 9'b1100_10100);
      apply("inc_wrap",    1'b0, 4'b1110, 4'b1111, 4'b0000, 1'b0, 9'b0000_01101);
      apply("inc_ovf",     1'b0, 4'b1110, 4'b0111, 4'b0000, 1'b0, 9'b1000_10010);
      apply("dec_zero",    1'b0, 4'b1111, 4'b0000, 4'b0000, 1'b0, 9'b1111_10000);
      apply("dec_ovf",     1'b0, 4'b1111, 4'b1000, 4'b0000, 1'b0, 9'b0111_00111);
`else
      for (int op = 10; op < 16; op++) begin
         apply($sformatf("undef_%0d", op), 1'b0, 4'(op), 4'b1011, 4'b0110, 1'b1,
               9'b0000_01000);
      end
`endif

      apply("final_add",   1'b0, OP_ADD,  4'b0010, 4'b0011, 1'b0, 9'b0101_00000);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
